gelu_array_feeder: RTL and testbench

Stream-side initiator for the GELU lane array. It accepts NUM_LANES-wide activation vectors from an upstream ready/valid stream and issues each one to the array as a single-cycle `valid_in` pulse. It captures every `valid_out` result into an output FIFO and re-emits the results, in order with their `last` tags, on a downstream ready/valid stream. Credit accounting guarantees that a result returned by the fixed-latency, non-stallable array always has a FIFO slot.

---
 rtl/gelu_array_feeder.sv | 218 +++++++++++++++++++++
 tb/tb_gelu_array_feeder.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gelu_array_feeder.sv
//------------------------------------------------------------------------------
// gelu_array_feeder
//
// Purpose:
//   Stream-side initiator for the GELU lane array. Vectors accepted from the
//   upstream ready/valid stream are issued to the array as single-cycle
//   valid_in pulses. Every result the array returns is captured, together with
//   the tile-last tag of the vector that produced it, into an output FIFO. The
//   FIFO is drained in order on the downstream ready/valid stream.
//   The array has a fixed latency and cannot be stalled. Credit accounting
//   therefore admits a new vector only while the sum of FIFO occupancy and
//   in-flight vectors is below DEPTH. This guarantees that every returning
//   result finds a free FIFO slot.
//
// Optional feature:
//   GELU_FEEDER_TIMEOUT_EN - when defined, a watchdog counts cycles in which
//   vectors are outstanding but nothing retires. It raises the sticky
//   o_err_timeout flag when the count reaches TIMEOUT. When the macro is
//   undefined, o_err_timeout is tied to 0.
//
// Ports:
//   i_clk            clock, all logic on posedge
//   i_rst_n          asynchronous active-low reset
//   i_s_valid        upstream vector valid
//   o_s_ready        upstream ready (credit available)
//   i_s_data         upstream vector, NUM_LANES words of W bits
//   i_s_last         upstream tile-last tag
//   o_arr_valid_in   one-cycle issue pulse to the array
//   o_arr_xi         vector presented to the array (held until next accept)
//   i_arr_valid_out  array result valid
//   i_arr_gelu_out   array result vector
//   o_m_valid        downstream valid (output FIFO not empty)
//   i_m_ready        downstream ready
//   o_m_data         head-of-FIFO result vector
//   o_m_last         head-of-FIFO tile-last tag
//   o_inflight       vectors issued to the array but not yet returned
//   o_err_overflow   sticky: a result arrived while nothing was outstanding
//   o_err_timeout    sticky watchdog flag (tied 0 without the macro)
//------------------------------------------------------------------------------
module gelu_array_feeder #(
  parameter int W         = 32,
  parameter int NUM_LANES = 32,
  parameter int DEPTH     = 4,
  parameter int TIMEOUT   = 64
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_s_valid,
  output logic                         o_s_ready,
  input  logic [W-1:0]                 i_s_data [NUM_LANES-1:0],
  input  logic                         i_s_last,
  output logic                         o_arr_valid_in,
  output logic [W-1:0]                 o_arr_xi [NUM_LANES-1:0],
  input  logic                         i_arr_valid_out,
  input  logic [W-1:0]                 i_arr_gelu_out [NUM_LANES-1:0],
  output logic                         o_m_valid,
  input  logic                         i_m_ready,
  output logic [W-1:0]                 o_m_data [NUM_LANES-1:0],
  output logic                         o_m_last,
  output logic [$clog2(DEPTH+1)-1:0]   o_inflight,
  output logic                         o_err_overflow,
  output logic                         o_err_timeout
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  // Pointer wrap relies on DEPTH being a power of two. Catch bad
  // parameterisations at elaboration time instead of at silicon time.
  generate
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (TIMEOUT < 1)) begin : g_bad_params
      $error("gelu_array_feeder: DEPTH must be a power of 2 >= 2 and TIMEOUT >= 1");
    end
  endgenerate

  logic                r_valid_in;
  logic [W-1:0]        r_arr_xi [NUM_LANES-1:0];
  logic [CW-1:0]       r_inflight;
  logic [CW-1:0]       r_fifo_count;
  logic                r_err_overflow;

  logic                r_tag_mem [DEPTH-1:0];
  logic [PW-1:0]       r_tag_wr;
  logic [PW-1:0]       r_tag_rd;

  logic [W-1:0]        r_data_mem [DEPTH-1:0][NUM_LANES-1:0];
  logic                r_last_mem [DEPTH-1:0];
  logic [PW-1:0]       r_wr_ptr;
  logic [PW-1:0]       r_rd_ptr;

  logic [CW-1:0]       w_used;
  logic                w_accept;
  logic                w_retire;
  logic                w_pop;

  // Credits are the FIFO slots not yet claimed by a stored result or by a
  // vector still inside the array. Both counters are registered, so ready
  // has no combinational path from any input.
  assign w_used     = r_fifo_count + r_inflight;
  assign o_s_ready  = (w_used != DEPTH_C);
  assign w_accept   = i_s_valid && o_s_ready;
  assign w_retire   = i_arr_valid_out && (r_inflight != '0);
  assign w_pop      = o_m_valid && i_m_ready;

  assign o_arr_valid_in = r_valid_in;
  assign o_arr_xi       = r_arr_xi;
  assign o_inflight     = r_inflight;
  assign o_err_overflow = r_err_overflow;
  assign o_m_valid      = (r_fifo_count != '0);
  assign o_m_data       = r_data_mem[r_rd_ptr];
  assign o_m_last       = r_last_mem[r_rd_ptr];

  // Issue stage: an accept turns into a one-cycle pulse. The vector stays on
  // o_arr_xi afterwards so the array may sample it at any point of that cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid_in <= 1'b0;
      for (int l = 0; l < NUM_LANES; l++) r_arr_xi[l] <= '0;
    end else begin
      r_valid_in <= w_accept;
      if (w_accept) r_arr_xi <= i_s_data;
    end
  end

  // Occupancy counters. Simultaneous increment and decrement cancel out.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_inflight   <= '0;
      r_fifo_count <= '0;
    end else begin
      case ({w_accept, w_retire})
        2'b10:   r_inflight <= r_inflight + CW'(1);
        2'b01:   r_inflight <= r_inflight - CW'(1);
        default: r_inflight <= r_inflight;
      endcase
      case ({w_retire, w_pop})
        2'b10:   r_fifo_count <= r_fifo_count + CW'(1);
        2'b01:   r_fifo_count <= r_fifo_count - CW'(1);
        default: r_fifo_count <= r_fifo_count;
      endcase
    end
  end

  // Tag FIFO: the array does not carry the last flag. The tags therefore ride
  // alongside in issue order and are re-attached when the result returns.
  // Occupancy always equals r_inflight, so it cannot overrun.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tag_wr <= '0;
      r_tag_rd <= '0;
      for (int d = 0; d < DEPTH; d++) r_tag_mem[d] <= 1'b0;
    end else begin
      if (w_accept) begin
        r_tag_mem[r_tag_wr] <= i_s_last;
        r_tag_wr            <= r_tag_wr + PW'(1);
      end
      if (w_retire) r_tag_rd <= r_tag_rd + PW'(1);
    end
  end

  // Output FIFO. A retire is guaranteed a free slot by the credit rule. The
  // head is read straight from storage, which keeps it stable under
  // back-pressure and means there is no same-cycle bypass.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int d = 0; d < DEPTH; d++) begin
        r_last_mem[d] <= 1'b0;
        for (int l = 0; l < NUM_LANES; l++) r_data_mem[d][l] <= '0;
      end
    end else begin
      if (w_retire) begin
        r_data_mem[r_wr_ptr] <= i_arr_gelu_out;
        r_last_mem[r_wr_ptr] <= r_tag_mem[r_tag_rd];
        r_wr_ptr             <= r_wr_ptr + PW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
    end
  end

  // A result with nothing outstanding is dropped. The event is remembered
  // until reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_err_overflow <= 1'b0;
    end else if (i_arr_valid_out && (r_inflight == '0)) begin
      r_err_overflow <= 1'b1;
    end
  end

`ifdef GELU_FEEDER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] r_wd_count;
  logic          r_err_timeout;

  // Watchdog: it counts idle-but-outstanding cycles and restarts on every
  // retire. The flag goes up on the cycle in which the count reaches TIMEOUT.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wd_count    <= '0;
      r_err_timeout <= 1'b0;
    end else if ((r_inflight == '0) || w_retire) begin
      r_wd_count <= '0;
    end else if (r_wd_count != TW'(TIMEOUT)) begin
      r_wd_count <= r_wd_count + TW'(1);
      if (r_wd_count == TW'(TIMEOUT - 1)) r_err_timeout <= 1'b1;
    end
  end

  assign o_err_timeout = r_err_timeout;
`else
  assign o_err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_gelu_array_feeder.sv
//------------------------------------------------------------------------------
// tb_gelu_array_feeder
//
// Purpose:
//   Drives gelu_array_feeder against a stub array. The stub has a fixed
//   latency of LAT cycles and returns x+1 on every lane. The scoreboard is
//   built from two queues: vectors sent into the array and results waiting
//   downstream. The bench predicts ready, valid, inflight and the head result
//   from those queues, and it compares the DUT outputs against the prediction
//   on every negative clock edge.
//------------------------------------------------------------------------------
module tb_gelu_array_feeder;

  localparam int W       = 32;
  localparam int NL      = 32;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 64;
  localparam int LAT     = 5;
  localparam int CW      = $clog2(DEPTH + 1);
  localparam int QV      = 6710886;

  typedef logic [W-1:0] vec_t [NL-1:0];
  typedef struct {
    vec_t d;
    logic last;
  } item_t;

  logic          clk = 1'b0;
  logic          rstN = 1'b1;
  logic          sValid, sReady, sLast;
  vec_t          sData;
  logic          arrValidIn;
  vec_t          arrXi;
  logic          arrValidOut;
  vec_t          arrGeluOut;
  logic          mValid, mReady, mLast;
  vec_t          mData;
  logic [CW-1:0] inflight;
  logic          errOverflow, errTimeout;

  logic          stubEnable, manualV;
  vec_t          manualD;
  logic          stubV [LAT];
  vec_t          stubD [LAT];

  item_t         pendQ[$];
  item_t         readyQ[$];
  bit            expOvf;
  bit            lastAcc;
  int            checks = 0;
  int            fails  = 0;

  always #5 clk = ~clk;

  gelu_array_feeder #(
    .W(W), .NUM_LANES(NL), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rstN),
    .i_s_valid(sValid),
    .o_s_ready(sReady),
    .i_s_data(sData),
    .i_s_last(sLast),
    .o_arr_valid_in(arrValidIn),
    .o_arr_xi(arrXi),
    .i_arr_valid_out(arrValidOut),
    .i_arr_gelu_out(arrGeluOut),
    .o_m_valid(mValid),
    .i_m_ready(mReady),
    .o_m_data(mData),
    .o_m_last(mLast),
    .o_inflight(inflight),
    .o_err_overflow(errOverflow),
    .o_err_timeout(errTimeout)
  );

  // Stub array: a fixed-latency, non-stallable pipeline that adds one to every
  // lane. The pipeline shares the DUT reset.
  always @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      for (int k = 0; k < LAT; k++) stubV[k] <= 1'b0;
    end else begin
      stubV[0] <= arrValidIn && stubEnable;
      for (int i = 0; i < NL; i++) stubD[0][i] <= arrXi[i] + W'(1);
      for (int k = 1; k < LAT; k++) begin
        stubV[k] <= stubV[k-1];
        stubD[k] <= stubD[k-1];
      end
    end
  end

  assign arrValidOut = stubV[LAT-1] | manualV;

  always_comb begin
    for (int i = 0; i < NL; i++) arrGeluOut[i] = manualV ? manualD[i] : stubD[LAT-1][i];
  end

  function automatic bit vecEq(input vec_t a, input vec_t b);
    for (int i = 0; i < NL; i++) if (a[i] !== b[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic modelReset();
    pendQ.delete();
    readyQ.delete();
    expOvf = 1'b0;
  endtask

  // Applies one clock edge and updates the scoreboard from the same inputs
  // the DUT sees at that edge. Call this task at a negative edge.
  task automatic advance();
    bit    acc, ret, pop, sv;
    item_t it;
    sv  = arrValidOut;
    acc = sValid && ((pendQ.size() + readyQ.size()) < DEPTH);
    ret = sv && (pendQ.size() != 0);
    pop = (readyQ.size() != 0) && mReady;
    if (sv && (pendQ.size() == 0)) expOvf = 1'b1;
    if (pop) void'(readyQ.pop_front());
    if (ret) readyQ.push_back(pendQ.pop_front());
    if (acc) begin
      for (int i = 0; i < NL; i++) it.d[i] = sData[i] + W'(1);
      it.last = sLast;
      pendQ.push_back(it);
    end
    lastAcc = acc;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    bit xiZero, dataZero;
    @(negedge clk);
    rstN = 1'b0;
    #1;
    modelReset();
    xiZero = 1'b1;
    dataZero = 1'b1;
    for (int i = 0; i < NL; i++) begin
      if (arrXi[i] !== '0) xiZero = 1'b0;
      if (mData[i] !== '0) dataZero = 1'b0;
    end
    checks++; if (sReady !== 1'b1) begin fails++; $display("[TB] FAIL reset_s_ready: got %b expected 1", sReady); end
    checks++; if (arrValidIn !== 1'b0) begin fails++; $display("[TB] FAIL reset_valid_in: got %b expected 0", arrValidIn); end
    checks++; if (!xiZero) begin fails++; $display("[TB] FAIL reset_arr_xi: got lane0 %h expected 0", arrXi[0]); end
    checks++; if (mValid !== 1'b0) begin fails++; $display("[TB] FAIL reset_m_valid: got %b expected 0", mValid); end
    checks++; if (!dataZero) begin fails++; $display("[TB] FAIL reset_m_data: got lane0 %h expected 0", mData[0]); end
    checks++; if (mLast !== 1'b0) begin fails++; $display("[TB] FAIL reset_m_last: got %b expected 0", mLast); end
    checks++; if (inflight !== '0) begin fails++; $display("[TB] FAIL reset_inflight: got %0d expected 0", inflight); end
    checks++; if (errOverflow !== 1'b0) begin fails++; $display("[TB] FAIL reset_err_overflow: got %b expected 0", errOverflow); end
    checks++; if (errTimeout !== 1'b0) begin fails++; $display("[TB] FAIL reset_err_timeout: got %b expected 0", errTimeout); end
    @(negedge clk);
    @(negedge clk);
    rstN = 1'b1;
  endtask

  task automatic test_single();
    vec_t inVec, expVec;
    int   avoCyc = -1;
    int   mvCyc = -1;
    for (int i = 0; i < NL; i++) begin
      inVec[i]  = W'(i * QV);
      expVec[i] = W'(i * QV + 1);
    end
    sData = inVec; sValid = 1'b1; sLast = 1'b1; mReady = 1'b1;
    checks++; if (sReady !== 1'b1) begin fails++; $display("[TB] FAIL single_s_ready: got %b expected 1", sReady); end
    advance();
    sValid = 1'b0;
    checks++; if (arrValidIn !== 1'b1) begin fails++; $display("[TB] FAIL single_pulse_high: got %b expected 1", arrValidIn); end
    checks++; if (!vecEq(arrXi, inVec)) begin fails++; $display("[TB] FAIL single_arr_xi: got lane1 %h expected %h", arrXi[1], inVec[1]); end
    advance();
    checks++; if (arrValidIn !== 1'b0) begin fails++; $display("[TB] FAIL single_pulse_low: got %b expected 0", arrValidIn); end
    checks++; if (!vecEq(arrXi, inVec)) begin fails++; $display("[TB] FAIL single_arr_xi_hold: got lane1 %h expected %h", arrXi[1], inVec[1]); end
    for (int c = 0; c < 20; c++) begin
      if ((arrValidOut === 1'b1) && (avoCyc < 0)) avoCyc = c;
      if ((mValid === 1'b1) && (mvCyc < 0)) begin
        mvCyc = c;
        checks++;
        if (!vecEq(mData, expVec) || (mLast !== 1'b1)) begin
          fails++;
          $display("[TB] FAIL single_m_data: got lane31 %h last %b expected %h last 1", mData[31], mLast, expVec[31]);
        end
      end
      advance();
    end
    checks++; if ((mvCyc < 0) || (mvCyc != avoCyc + 1)) begin fails++; $display("[TB] FAIL single_capture_latency: got m_valid at %0d expected %0d", mvCyc, avoCyc + 1); end
    checks++; if (mvCyc != LAT) begin fails++; $display("[TB] FAIL single_end_to_end: got %0d expected %0d", mvCyc, LAT); end
    checks++; if (mValid !== 1'b0) begin fails++; $display("[TB] FAIL single_drained: got %b expected 0", mValid); end
  endtask

  task automatic test_back_to_back();
    vec_t vecs [8];
    int   idx = 0;
    int   cyc = 0;
    int   outCnt = 0;
    int   maxInfl = 0;
    bit   sawNotReady = 1'b0;
    for (int v = 0; v < 8; v++) for (int i = 0; i < NL; i++) vecs[v][i] = $urandom;
    mReady = 1'b1;
    while (((idx < 8) || (pendQ.size() != 0) || (readyQ.size() != 0)) && (cyc < 100)) begin
      sValid = (idx < 8);
      if (idx < 8) sData = vecs[idx];
      sLast = (idx == 7);
      checks++; if (sReady !== ((pendQ.size() + readyQ.size()) < DEPTH)) begin fails++; $display("[TB] FAIL b2b_s_ready: got %b at cycle %0d", sReady, cyc); end
      checks++; if (mValid !== (readyQ.size() != 0)) begin fails++; $display("[TB] FAIL b2b_m_valid: got %b expected %b", mValid, readyQ.size() != 0); end
      if (readyQ.size() != 0) begin
        checks++;
        if (!vecEq(mData, readyQ[0].d) || (mLast !== readyQ[0].last)) begin
          fails++;
          $display("[TB] FAIL b2b_head: got lane0 %h last %b expected %h last %b", mData[0], mLast, readyQ[0].d[0], readyQ[0].last);
        end
      end
      checks++; if (inflight !== CW'(pendQ.size())) begin fails++; $display("[TB] FAIL b2b_inflight: got %0d expected %0d", inflight, pendQ.size()); end
      if (mValid === 1'b1) outCnt++;
      if (sReady === 1'b0) sawNotReady = 1'b1;
      if (int'(inflight) > maxInfl) maxInfl = int'(inflight);
      advance();
      if (lastAcc) idx++;
      cyc++;
    end
    sValid = 1'b0; sLast = 1'b0;
    checks++; if ((idx != 8) || (pendQ.size() != 0) || (readyQ.size() != 0)) begin fails++; $display("[TB] FAIL b2b_complete: got %0d accepted expected 8 within budget", idx); end
    checks++; if (outCnt != 8) begin fails++; $display("[TB] FAIL b2b_out_count: got %0d expected 8", outCnt); end
    checks++; if (!sawNotReady) begin fails++; $display("[TB] FAIL b2b_credit_stall: got no s_ready drop expected one"); end
    checks++; if (maxInfl > DEPTH) begin fails++; $display("[TB] FAIL b2b_inflight_max: got %0d expected <= %0d", maxInfl, DEPTH); end
  endtask

  task automatic test_backpressure();
    vec_t vecs [6];
    int   idx = 0;
    int   dutAcc = 0;
    int   outCnt = 0;
    int   cyc = 0;
    for (int v = 0; v < 6; v++) for (int i = 0; i < NL; i++) vecs[v][i] = $urandom;
    mReady = 1'b0; sLast = 1'b0;
    for (int c = 0; c < 20; c++) begin
      sValid = 1'b1;
      sData = vecs[idx];
      checks++; if (sReady !== ((pendQ.size() + readyQ.size()) < DEPTH)) begin fails++; $display("[TB] FAIL bp_s_ready: got %b at cycle %0d", sReady, c); end
      if (readyQ.size() != 0) begin
        checks++;
        if (!vecEq(mData, readyQ[0].d)) begin fails++; $display("[TB] FAIL bp_head_stable: got lane0 %h expected %h", mData[0], readyQ[0].d[0]); end
      end
      if (sReady === 1'b1) dutAcc++;
      advance();
      if (lastAcc) idx++;
    end
    checks++; if (dutAcc != DEPTH) begin fails++; $display("[TB] FAIL bp_accept_count: got %0d expected %0d", dutAcc, DEPTH); end
    checks++; if (sReady !== 1'b0) begin fails++; $display("[TB] FAIL bp_stalled_ready: got %b expected 0", sReady); end
    checks++; if (mValid !== 1'b1) begin fails++; $display("[TB] FAIL bp_m_valid: got %b expected 1", mValid); end
    mReady = 1'b1;
    while (((idx < 6) || (pendQ.size() != 0) || (readyQ.size() != 0)) && (cyc < 100)) begin
      sValid = (idx < 6);
      if (idx < 6) sData = vecs[idx];
      checks++; if (sReady !== ((pendQ.size() + readyQ.size()) < DEPTH)) begin fails++; $display("[TB] FAIL bp_drain_s_ready: got %b at cycle %0d", sReady, cyc); end
      checks++; if (mValid !== (readyQ.size() != 0)) begin fails++; $display("[TB] FAIL bp_drain_m_valid: got %b expected %b", mValid, readyQ.size() != 0); end
      if (readyQ.size() != 0) begin
        checks++;
        if (!vecEq(mData, readyQ[0].d)) begin fails++; $display("[TB] FAIL bp_drain_head: got lane0 %h expected %h", mData[0], readyQ[0].d[0]); end
      end
      if (mValid === 1'b1) outCnt++;
      advance();
      if (lastAcc) idx++;
      cyc++;
    end
    sValid = 1'b0;
    checks++; if (outCnt != 6) begin fails++; $display("[TB] FAIL bp_out_count: got %0d expected 6", outCnt); end
    checks++; if ((idx != 6) || (pendQ.size() != 0) || (readyQ.size() != 0)) begin fails++; $display("[TB] FAIL bp_complete: got %0d accepted expected 6 within budget", idx); end
  endtask

  task automatic test_tile();
    int idx = 0;
    int outIdx = 0;
    int cyc = 0;
    mReady = 1'b1;
    while (((idx < 3) || (outIdx < 3)) && (cyc < 60)) begin
      sValid = (idx < 3);
      sLast = (idx == 2);
      for (int i = 0; i < NL; i++) sData[i] = $urandom;
      if (mValid === 1'b1) begin
        checks++;
        if (mLast !== (outIdx == 2)) begin fails++; $display("[TB] FAIL tile_last: got %b on output %0d expected %b", mLast, outIdx, outIdx == 2); end
        outIdx++;
      end
      advance();
      if (lastAcc) idx++;
      cyc++;
    end
    sValid = 1'b0; sLast = 1'b0;
    checks++; if (outIdx != 3) begin fails++; $display("[TB] FAIL tile_count: got %0d expected 3", outIdx); end
  endtask

  task automatic test_random();
    vec_t cur;
    int   idx = 0;
    int   cyc = 0;
    for (int i = 0; i < NL; i++) cur[i] = $urandom;
    while (((idx < 30) || (pendQ.size() != 0) || (readyQ.size() != 0)) && (cyc < 800)) begin
      sValid = (idx < 30) && ($urandom_range(0, 99) < 70);
      mReady = ($urandom_range(0, 99) < 60);
      sLast = $urandom_range(0, 1);
      sData = cur;
      checks++; if (sReady !== ((pendQ.size() + readyQ.size()) < DEPTH)) begin fails++; $display("[TB] FAIL rnd_s_ready: got %b at cycle %0d", sReady, cyc); end
      checks++; if (mValid !== (readyQ.size() != 0)) begin fails++; $display("[TB] FAIL rnd_m_valid: got %b expected %b", mValid, readyQ.size() != 0); end
      if (readyQ.size() != 0) begin
        checks++;
        if (!vecEq(mData, readyQ[0].d) || (mLast !== readyQ[0].last)) begin
          fails++;
          $display("[TB] FAIL rnd_head: got lane0 %h last %b expected %h last %b", mData[0], mLast, readyQ[0].d[0], readyQ[0].last);
        end
      end
      checks++; if (inflight !== CW'(pendQ.size())) begin fails++; $display("[TB] FAIL rnd_inflight: got %0d expected %0d", inflight, pendQ.size()); end
      checks++; if (errOverflow !== expOvf) begin fails++; $display("[TB] FAIL rnd_err_overflow: got %b expected %b", errOverflow, expOvf); end
      advance();
      if (lastAcc) begin
        idx++;
        for (int i = 0; i < NL; i++) cur[i] = $urandom;
      end
      cyc++;
    end
    sValid = 1'b0; mReady = 1'b1; sLast = 1'b0;
    checks++; if ((idx != 30) || (pendQ.size() != 0) || (readyQ.size() != 0)) begin fails++; $display("[TB] FAIL rnd_complete: got %0d accepted expected 30 within budget", idx); end
  endtask

  task automatic test_overflow();
    mReady = 1'b1;
    manualV = 1'b1;
    for (int i = 0; i < NL; i++) manualD[i] = $urandom;
    advance();
    manualV = 1'b0;
    checks++; if (errOverflow !== 1'b1) begin fails++; $display("[TB] FAIL ovf_set: got %b expected 1", errOverflow); end
    checks++; if (mValid !== 1'b0) begin fails++; $display("[TB] FAIL ovf_no_write: got %b expected 0", mValid); end
    checks++; if (inflight !== '0) begin fails++; $display("[TB] FAIL ovf_inflight: got %0d expected 0", inflight); end
    repeat (5) advance();
    checks++; if (errOverflow !== 1'b1) begin fails++; $display("[TB] FAIL ovf_sticky: got %b expected 1", errOverflow); end
    checks++; if (mValid !== 1'b0) begin fails++; $display("[TB] FAIL ovf_m_valid_idle: got %b expected 0", mValid); end
    rstN = 1'b0;
    #1;
    checks++; if (errOverflow !== 1'b0) begin fails++; $display("[TB] FAIL ovf_reset_clear: got %b expected 0", errOverflow); end
    @(negedge clk);
    rstN = 1'b1;
    modelReset();
  endtask

  task automatic test_timeout();
    int k = 0;
    bit seen = 1'b0;
    stubEnable = 1'b0;
    mReady = 1'b1;
    sValid = 1'b1;
    sLast = 1'b0;
    for (int i = 0; i < NL; i++) sData[i] = $urandom;
    advance();
    sValid = 1'b0;
    checks++; if (inflight !== CW'(1)) begin fails++; $display("[TB] FAIL tmo_inflight: got %0d expected 1", inflight); end
`ifdef GELU_FEEDER_TIMEOUT_EN
    while ((errTimeout !== 1'b1) && (k < 200)) begin
      advance();
      k++;
    end
    checks++; if (k != TIMEOUT) begin fails++; $display("[TB] FAIL tmo_latency: got %0d cycles expected %0d", k, TIMEOUT); end
    repeat (3) advance();
    checks++; if (errTimeout !== 1'b1) begin fails++; $display("[TB] FAIL tmo_sticky: got %b expected 1", errTimeout); end
`else
    repeat (TIMEOUT + 20) begin
      advance();
      if (errTimeout !== 1'b0) seen = 1'b1;
      k++;
    end
    checks++; if (seen) begin fails++; $display("[TB] FAIL tmo_tied_low: got 1 within %0d cycles expected 0", k); end
`endif
    rstN = 1'b0;
    #1;
    checks++; if (inflight !== '0) begin fails++; $display("[TB] FAIL tmo_reset_inflight: got %0d expected 0", inflight); end
    checks++; if (sReady !== 1'b1) begin fails++; $display("[TB] FAIL tmo_reset_s_ready: got %b expected 1", sReady); end
    checks++; if (errTimeout !== 1'b0) begin fails++; $display("[TB] FAIL tmo_reset_flag: got %b expected 0", errTimeout); end
    @(negedge clk);
    rstN = 1'b1;
    modelReset();
    stubEnable = 1'b1;
  endtask

  // Global guard: every loop above has its own bound, so this should never
  // fire.
  initial begin
    #3000000;
    $display("[TB] FAIL global_timeout: simulation exceeded its time budget");
    $fatal(1, "[TB] global timeout");
  end

  initial begin
    sValid = 1'b0; sLast = 1'b0; mReady = 1'b1;
    manualV = 1'b0; stubEnable = 1'b1; expOvf = 1'b0; lastAcc = 1'b0;
    for (int i = 0; i < NL; i++) begin
      sData[i] = '0;
      manualD[i] = '0;
    end
    repeat (2) @(negedge clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_tile();
    test_random();
    test_overflow();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
